// File: rtl/instr_cache_pkg.sv
// ---------------------------------------------------------------------------
// instr_cache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   icache_state_e : refill controller states (IDLE, REFILL, FILL_DONE)
//   INSTR_NOP      : canonical RISC-V nop encoding (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package instr_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } icache_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/icache_refill_fsm.sv
// ---------------------------------------------------------------------------
// icache_refill_fsm
// Refill controller for the instruction cache. Owns the state register, the
// beat counter, the latched miss line address and the pending-invalidate
// flag, and runs the beat-by-beat handshake with backing memory.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   miss_i          lookup missed (only acted on in IDLE)
//   inv_i           invalidate-all request
//   mem_ready_i     backing memory accepted the current beat
//   line_addr_i     PCF with offset bits cleared
//   state_o         current controller state
//   beat_o          word index of the beat currently being fetched
//   line_addr_o     latched miss line address
//   mem_req_o       beat request to backing memory
//   mem_addr_o      word-aligned address of the requested beat
//   fill_we_o       write the returned beat into the data array
//   fill_done_o     mark the latched line valid and write its tag
//   clear_valid_o   clear every valid bit this edge
// ---------------------------------------------------------------------------
module icache_refill_fsm
  import instr_cache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_i,
  input  logic               inv_i,
  input  logic               mem_ready_i,
  input  logic [WIDTH-1:0]   line_addr_i,
  output icache_state_e      state_o,
  output logic [OFF_W-1:0]   beat_o,
  output logic [WIDTH-1:0]   line_addr_o,
  output logic               mem_req_o,
  output logic [WIDTH-1:0]   mem_addr_o,
  output logic               fill_we_o,
  output logic               fill_done_o,
  output logic               clear_valid_o
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  icache_state_e    state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [WIDTH-1:0] lineAddr_q, lineAddr_d;
  logic             pendInv_q, pendInv_d;

  // Control state register. The line address is plain datapath and is only
  // meaningful while a refill is in flight, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pendInv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pendInv_q <= pendInv_d;
    end
  end

  always_ff @(posedge clk) begin
    lineAddr_q <= lineAddr_d;
  end

  // Next-state and handshake decode. While reset is asserted every strobe is
  // forced low so an abandoned refill neither requests nor writes anything.
  // An invalidate seen mid-refill is parked in pendInv and applied on the
  // FILL_DONE->IDLE edge, overriding the valid bit set by that same fill.
  // The beat counter holds at the last beat and is only rewound on a new
  // IDLE->REFILL transition.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    lineAddr_d    = lineAddr_q;
    pendInv_d     = pendInv_q;
    mem_req_o     = 1'b0;
    fill_we_o     = 1'b0;
    fill_done_o   = 1'b0;
    clear_valid_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          pendInv_d = 1'b0;
          if (inv_i) begin
            clear_valid_o = 1'b1;
          end else if (miss_i) begin
            state_d    = REFILL;
            beat_d     = '0;
            lineAddr_d = line_addr_i;
          end
        end
        REFILL: begin
          mem_req_o = 1'b1;
          if (inv_i) begin
            pendInv_d = 1'b1;
          end
          if (mem_ready_i) begin
            fill_we_o = 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_d = FILL_DONE;
            end else begin
              beat_d = beat_q + OFF_W'(1);
            end
          end
        end
        FILL_DONE: begin
          fill_done_o   = 1'b1;
          clear_valid_o = pendInv_q | inv_i;
          pendInv_d     = 1'b0;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign beat_o      = beat_q;
  assign line_addr_o = lineAddr_q;
  assign mem_addr_o  = lineAddr_q + (WIDTH'(beat_q) << 2);

endmodule

// File: rtl/instr_cache.sv
// ---------------------------------------------------------------------------
// instr_cache
// Direct-mapped, read-only instruction cache with zero-cycle hit latency and
// whole-line refill from a simple ready-handshaked backing memory.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   PCF         fetch address (bits [1:0] ignored)
//   inv         invalidate all lines (fence.i)
//   InstrF      instruction at PCF on a hit, zero otherwise
//   StallF      fetch must hold its PC (InstrF not valid)
//   mem_req     refill beat request
//   mem_addr    word-aligned refill beat address
//   mem_ready   beat accepted, mem_rdata valid this cycle
//   mem_rdata   refill beat data
// ---------------------------------------------------------------------------
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  input  logic             inv,
  output logic [WIDTH-1:0] InstrF,
  output logic             StallF,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = WIDTH - TAG_LO;

  logic [WIDTH-1:0] data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  logic [OFF_W-1:0] pcOff;
  logic [IDX_W-1:0] pcIdx;
  logic [TAG_W-1:0] pcTag;
  logic [WIDTH-1:0] pcLine;
  logic             hit;

  icache_state_e    fsmState;
  logic [OFF_W-1:0] fsmBeat;
  logic [WIDTH-1:0] fsmLine;
  logic             fillWe;
  logic             fillDone;
  logic             clearValid;
  logic [IDX_W-1:0] fillIdx;
  logic [TAG_W-1:0] fillTag;
  logic             unusedBits;

  assign pcOff  = PCF[IDX_LO-1:2];
  assign pcIdx  = PCF[TAG_LO-1:IDX_LO];
  assign pcTag  = PCF[WIDTH-1:TAG_LO];
  assign pcLine = {PCF[WIDTH-1:IDX_LO], {IDX_LO{1'b0}}};

  assign fillIdx = fsmLine[TAG_LO-1:IDX_LO];
  assign fillTag = fsmLine[WIDTH-1:TAG_LO];

  assign unusedBits = ^{PCF[1:0], fsmLine[IDX_LO-1:0]};

  // Lookup is only trusted in IDLE with no reset or invalidate in flight;
  // during reset nothing stalls so the fetch stage sees a clean restart.
  assign hit    = (fsmState == IDLE) && !rst && !inv &&
                  valid_q[pcIdx] && (tag_q[pcIdx] == pcTag);
  assign StallF = !rst && !hit;
  assign InstrF = hit ? data_q[pcIdx][pcOff] : '0;

  icache_refill_fsm #(
    .WIDTH      (WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk           (clk),
    .rst           (rst),
    .miss_i        (!hit),
    .inv_i         (inv),
    .mem_ready_i   (mem_ready),
    .line_addr_i   (pcLine),
    .state_o       (fsmState),
    .beat_o        (fsmBeat),
    .line_addr_o   (fsmLine),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .fill_we_o     (fillWe),
    .fill_done_o   (fillDone),
    .clear_valid_o (clearValid)
  );

  // Valid bits: the invalidate clear takes priority over the fill completing
  // in the same cycle, which is how a fill raced by fence.i ends invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clearValid) begin
      valid_q <= '0;
    end else if (fillDone) begin
      valid_q[fillIdx] <= 1'b1;
    end
  end

  // Tag and data storage have no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fillDone) begin
      tag_q[fillIdx] <= fillTag;
    end
    if (fillWe) begin
      data_q[fillIdx][fsmBeat] <= mem_rdata;
    end
  end

endmodule
